// File: rtl/fc_port_state_rx_seq.sv
// FC_Port receive state machine with a consecutive-match filter on primitive sequences,
// an IDLE hold-off before reporting Active, local link-reset request and LR recovery timeout.

package fc;

    typedef enum logic [3:0] {
        STATE_AC,
        STATE_LR1,
        STATE_LR2,
        STATE_LR3,
        STATE_LF1,
        STATE_LF2,
        STATE_OL1,
        STATE_OL2,
        STATE_OL3
    } state_t;

    typedef enum logic [2:0] {
        PRIM_NONE,
        PRIM_IDLE,
        PRIM_ARBFF,
        PRIM_OLS,
        PRIM_NOS,
        PRIM_LR,
        PRIM_LRR
    } prim_t;

    // K28.5 leads every ordered set; remaining bytes are the 8b data values.
    localparam logic [31:0] OS_IDLE  = 32'hBC95_B5B5;
    localparam logic [31:0] OS_ARBFF = 32'hBC94_FFFF;
    localparam logic [31:0] OS_OLS   = 32'hBC35_8A55;
    localparam logic [31:0] OS_NOS   = 32'hBC55_BF45;
    localparam logic [31:0] OS_LR    = 32'hBC49_BF49;
    localparam logic [31:0] OS_LRR   = 32'hBC35_BF49;

    function automatic prim_t map_primitive(input logic [31:0] word);
        prim_t p;
        case (word)
            OS_IDLE:  p = PRIM_IDLE;
            OS_ARBFF: p = PRIM_ARBFF;
            OS_OLS:   p = PRIM_OLS;
            OS_NOS:   p = PRIM_NOS;
            OS_LR:    p = PRIM_LR;
            OS_LRR:   p = PRIM_LRR;
            default:  p = PRIM_NONE;
        endcase
        return p;
    endfunction

endpackage

module fc_port_state_rx_seq #(
    parameter int unsigned SEQ_MATCH_COUNT = 3,
    parameter int unsigned IDLE_HOLDOFF    = 6,
    parameter int unsigned LR_TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [3:0]  datak,
    input  logic        link_reset_req,
    output fc::state_t  state,
    output logic        is_active,
    output logic        state_changed,
    output logic        lr_timeout
);

    localparam int unsigned MatchW = $clog2(SEQ_MATCH_COUNT + 1);
    localparam int unsigned HoldW  = (IDLE_HOLDOFF > 0) ? $clog2(IDLE_HOLDOFF + 1) : 1;
    localparam int unsigned TimerW = $clog2(LR_TIMEOUT + 1);

    localparam logic [MatchW-1:0] MatchMax  = MatchW'(SEQ_MATCH_COUNT);
    localparam logic [HoldW-1:0]  HoldInit  = HoldW'(IDLE_HOLDOFF);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(LR_TIMEOUT - 1);

    fc::state_t        state_q, state_d;
    fc::prim_t         last_q, last_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              changed_q, changed_d;
    logic              tmo_q, tmo_d;

    fc::prim_t  prim;
    fc::state_t target;
    logic       is_seq;
    logic       recognised;
    logic       prim_trans;
    logic       in_lr;

    always_comb begin
        prim       = (datak == 4'b1000) ? fc::map_primitive(data) : fc::PRIM_NONE;
        is_seq     = prim inside {fc::PRIM_OLS, fc::PRIM_NOS, fc::PRIM_LR, fc::PRIM_LRR};
        in_lr      = state_q inside {fc::STATE_LR1, fc::STATE_LR2, fc::STATE_LR3};

        match_d = '0;
        last_d  = fc::PRIM_NONE;
        if (is_seq) begin
            last_d = prim;
            if (prim == last_q && match_q != '0) begin
                match_d = (match_q == MatchMax) ? MatchMax : match_q + MatchW'(1);
            end else begin
                match_d = MatchW'(1);
            end
        end

        recognised = (is_seq && match_d == MatchMax) ||
                     prim inside {fc::PRIM_IDLE, fc::PRIM_ARBFF};

        target = state_q;
        case (prim)
            fc::PRIM_OLS: target = fc::STATE_OL2;
            fc::PRIM_NOS: target = fc::STATE_LF1;
            fc::PRIM_LR: begin
                target = (state_q inside {fc::STATE_OL3, fc::STATE_LF2}) ? fc::STATE_LF2
                                                                          : fc::STATE_LR2;
            end
            fc::PRIM_LRR: begin
                if (state_q inside {fc::STATE_LF1, fc::STATE_LF2, fc::STATE_OL1}) begin
                    target = state_q;
                end else if (state_q == fc::STATE_OL3) begin
                    target = fc::STATE_LF2;
                end else begin
                    target = fc::STATE_LR3;
                end
            end
            fc::PRIM_IDLE, fc::PRIM_ARBFF: begin
                if (state_q inside {fc::STATE_LR2, fc::STATE_LR3}) begin
                    target = fc::STATE_AC;
                end else if (state_q == fc::STATE_OL3) begin
                    target = fc::STATE_OL2;
                end
            end
            default: target = state_q;
        endcase

        // A recognised primitive that leaves the state as-is does not pre-empt lower priorities.
        prim_trans = recognised && (target != state_q);

        state_d = state_q;
        tmo_d   = 1'b0;
        if (prim_trans) begin
            state_d = target;
        end else if (in_lr && timer_q == TimerLast) begin
            state_d = fc::STATE_LF1;
            tmo_d   = 1'b1;
        end else if (state_q == fc::STATE_AC && link_reset_req) begin
            state_d = fc::STATE_LR1;
        end

        changed_d = (state_d != state_q);

        if (changed_d || !(state_d inside {fc::STATE_LR1, fc::STATE_LR2, fc::STATE_LR3})) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TimerW'(1);
        end

        if (state_q != fc::STATE_AC) begin
            hold_d = HoldInit;
        end else begin
            hold_d = (hold_q != '0) ? hold_q - HoldW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= fc::STATE_LF2;
            last_q    <= fc::PRIM_NONE;
            match_q   <= '0;
            hold_q    <= HoldInit;
            timer_q   <= '0;
            changed_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            match_q   <= match_d;
            hold_q    <= hold_d;
            timer_q   <= timer_d;
            changed_q <= changed_d;
            tmo_q     <= tmo_d;
        end
    end

    assign state         = state_q;
    assign is_active     = (state_q == fc::STATE_AC) && (hold_q == '0);
    assign state_changed = changed_q;
    assign lr_timeout    = tmo_q;

endmodule
